// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    // Active-low: all segments dark, all anodes off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Glyph lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit 7-segment display with blanking gaps,
// per-frame data snapshot, digit enable mask and leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk_100mhz,
    input  logic                    reset_n,
    input  logic                    scan_tick,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lzs_en,
    output logic [NUM_DIGITS-1:0]   digit_select,
    output logic [NUM_DIGITS-1:0]   digit_select_off,
    output logic [6:0]              seven,
    output logic                    frame_done
);

    localparam int         SLOT_W     = $clog2(NUM_DIGITS);
    localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic                    fd_q, fd_d;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] src;
    logic [3:0]              nib;
    logic [3:0]              nib_zero;
    logic [3:0]              upper_zero;
    logic                    show;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   drive_sel;
    logic [6:0]              drive_seg;

    // Unused board digits stay dark.
    assign digit_select_off = ANODE_OFF;

    // Slot 0 of a new frame is decoded straight from digits_in so the fresh
    // snapshot is visible on the same edge it is captured.
    always_comb begin
        load = (state_q == S_BLANK) && (cnt_q == 8'd0) && (slot_q == '0);
        src  = load ? digits_in : shadow_q;
        nib  = src[{slot_q, 2'b00} +: 4];
    end

    // A digit is a leading zero when it and every higher nibble are zero.
    always_comb begin
        nib_zero[0]   = (src[3:0]   == 4'h0);
        nib_zero[1]   = (src[7:4]   == 4'h0);
        nib_zero[2]   = (src[11:8]  == 4'h0);
        nib_zero[3]   = (src[15:12] == 4'h0);
        upper_zero[3] = nib_zero[3];
        upper_zero[2] = &nib_zero[3:2];
        upper_zero[1] = &nib_zero[3:1];
        upper_zero[0] = &nib_zero[3:0];
    end

    hex_to_seg7 u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    // Per-slot drive pattern; enable mask and suppression act live.
    always_comb begin
        show = digit_en[slot_q] &&
               !(lzs_en && (slot_q != '0) && upper_zero[slot_q]);
        drive_sel = show ? ~(NUM_DIGITS'(1) << slot_q) : ANODE_OFF;
        drive_seg = show ? dec_seg : SEG_BLANK;
    end

    // Next-state: drive until a tick, then blank for BLANK_CYCLES cycles.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        sel_d    = sel_q;
        seg_d    = seg_q;
        fd_d     = 1'b0;
        case (state_q)
            S_DRIVE: begin
                if (scan_tick) begin
                    state_d = S_BLANK;
                    slot_d  = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
                    cnt_d   = BLANK_INIT;
                    sel_d   = ANODE_OFF;
                    seg_d   = SEG_BLANK;
                end else begin
                    sel_d = drive_sel;
                    seg_d = drive_seg;
                end
            end
            default: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DRIVE;
                    sel_d   = drive_sel;
                    seg_d   = drive_seg;
                    if (slot_q == '0) begin
                        shadow_d = digits_in;
                        fd_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_BLANK;
            slot_q   <= '0;
            cnt_q    <= BLANK_INIT;
            shadow_q <= '0;
            sel_q    <= ANODE_OFF;
            seg_q    <= SEG_BLANK;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign digit_select = sel_q;
    assign seven        = seg_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with BLANK_CYCLES=4.
module tb_seg7_scan_ctrl;

    logic        clk_100mhz = 1'b0;
    logic        reset_n    = 1'b0;
    logic        scan_tick  = 1'b0;
    logic [15:0] digits_in  = 16'h1234;
    logic [3:0]  digit_en   = 4'b1111;
    logic        lzs_en     = 1'b0;
    logic [3:0]  digit_select;
    logic [3:0]  digit_select_off;
    logic [6:0]  seven;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Expected value of the slot currently on the bus (held-value check).
    logic [3:0] cur_sel;
    logic [6:0] cur_seg;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .BLANK_CYCLES(4)) dut (
        .clk_100mhz       (clk_100mhz),
        .reset_n          (reset_n),
        .scan_tick        (scan_tick),
        .digits_in        (digits_in),
        .digit_en         (digit_en),
        .lzs_en           (lzs_en),
        .digit_select     (digit_select),
        .digit_select_off (digit_select_off),
        .seven            (seven),
        .frame_done       (frame_done)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    // Hold the current slot, tick once, count the dark cycles that follow,
    // then return the outputs of the next slot's first cycle.
    task automatic advance(input int hold,
                           output logic [3:0] h_sel, output logic [6:0] h_seg,
                           output int blank_len,
                           output logic [3:0] n_sel, output logic [6:0] n_seg,
                           output logic n_fd);
        repeat (hold) step();
        h_sel = digit_select;
        h_seg = seven;
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        blank_len = (digit_select == 4'b1111 && seven == 7'b1111111) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (digit_select == 4'b1111 && seven == 7'b1111111) blank_len++;
        end
        step();
        n_sel = digit_select;
        n_seg = seven;
        n_fd  = frame_done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++; if (digit_select !== 4'b1111) begin errors++; $display("FAIL reset_sel got %b want 1111", digit_select); end
        checks++; if (seven !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b want 1111111", seven); end
        checks++; if (digit_select_off !== 4'b1111) begin errors++; $display("FAIL reset_off got %b want 1111", digit_select_off); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
        reset_n = 1'b1;
        repeat (3) step();
        checks++; if (digit_select !== 4'b1111) begin errors++; $display("FAIL first_blank got %b want 1111", digit_select); end
        step();
        checks++; if (digit_select !== 4'b1110) begin errors++; $display("FAIL first_sel got %b want 1110", digit_select); end
        checks++; if (seven !== 7'b0011001) begin errors++; $display("FAIL first_seg got %b want 0011001", seven); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL first_fd got %b want 1", frame_done); end
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL first_fd_drop got %b want 0", frame_done); end
        cur_sel = 4'b1110;
        cur_seg = 7'b0011001;
    endtask

    // Run a table of slots and check held value, blank length and new slot.
    task automatic run_table(input string name, input int n, input int hold,
                             input logic [3:0] es [8], input logic [6:0] eg [8],
                             input logic ef [8]);
        logic [3:0] hs, ns;
        logic [6:0] hg, ng;
        logic       nf;
        int         bl;
        for (int k = 0; k < n; k++) begin
            advance(hold, hs, hg, bl, ns, ng, nf);
            checks++; if (hs !== cur_sel || hg !== cur_seg) begin errors++; $display("FAIL %s held[%0d] got %b/%b want %b/%b", name, k, hs, hg, cur_sel, cur_seg); end
            checks++; if (bl != 4) begin errors++; $display("FAIL %s blank_len[%0d] got %0d want 4", name, k, bl); end
            checks++; if (ns !== es[k]) begin errors++; $display("FAIL %s sel[%0d] got %b want %b", name, k, ns, es[k]); end
            checks++; if (ng !== eg[k]) begin errors++; $display("FAIL %s seg[%0d] got %b want %b", name, k, ng, eg[k]); end
            checks++; if (nf !== ef[k]) begin errors++; $display("FAIL %s fd[%0d] got %b want %b", name, k, nf, ef[k]); end
            cur_sel = es[k];
            cur_seg = eg[k];
        end
    endtask

    task automatic test_full_scan();
        logic [3:0] es [8] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [6:0] eg [8] = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic       ef [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_table("full_scan", 4, 15, es, eg, ef);
    endtask

    task automatic test_anti_tearing();
        logic [3:0] es1 [8] = '{4'b1101, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [6:0] eg1 [8] = '{7'b0110000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic       ef1 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] es2 [8] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'hF, 4'hF};
        logic [6:0] eg2 [8] = '{7'b0100100, 7'b1111001, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, 7'h7F, 7'h7F};
        logic       ef2 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_table("tear_pre", 1, 5, es1, eg1, ef1);
        digits_in = 16'h5678;
        run_table("tear", 6, 5, es2, eg2, ef2);
    endtask

    task automatic test_lzs();
        logic [3:0] es1 [8] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [6:0] eg1 [8] = '{7'b1000000, 7'b1111000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic       ef1 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] es2 [8] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [6:0] eg2 [8] = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic       ef2 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lzs_en    = 1'b1;
        digits_in = 16'h0070;
        run_table("lzs_0070", 4, 5, es1, eg1, ef1);
        digits_in = 16'h0000;
        run_table("lzs_0000", 4, 5, es2, eg2, ef2);
    endtask

    task automatic test_enable();
        logic [3:0] es [8] = '{4'b1110, 4'b1111, 4'b1011, 4'b1111, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [6:0] eg [8] = '{7'b0011001, 7'h7F, 7'b0100100, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic       ef [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lzs_en    = 1'b0;
        digit_en  = 4'b0101;
        digits_in = 16'h1234;
        run_table("enable", 4, 5, es, eg, ef);
    endtask

    task automatic test_tick_in_blank();
        logic [3:0] es [8] = '{4'b1101, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [6:0] eg [8] = '{7'b0110000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic       ef [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        digit_en = 4'b1111;
        step();
        checks++; if (digit_select !== 4'b0111 || seven !== 7'b1111001) begin errors++; $display("FAIL live_en got %b/%b want 0111/1111001", digit_select, seven); end
        scan_tick = 1'b1;
        repeat (3) step();
        scan_tick = 1'b0;
        step();
        checks++; if (digit_select !== 4'b1111) begin errors++; $display("FAIL held_tick_blank got %b want 1111", digit_select); end
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        checks++; if (digit_select !== 4'b1110 || seven !== 7'b0011001) begin errors++; $display("FAIL tick_at_expiry got %b/%b want 1110/0011001", digit_select, seven); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL tick_at_expiry_fd got %b want 1", frame_done); end
        cur_sel = 4'b1110;
        cur_seg = 7'b0011001;
        run_table("after_blank_ticks", 1, 5, es, eg, ef);
    endtask

    task automatic test_mid_drive_reset();
        repeat (2) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (digit_select !== 4'b1111) begin errors++; $display("FAIL async_reset_sel got %b want 1111", digit_select); end
        checks++; if (seven !== 7'b1111111) begin errors++; $display("FAIL async_reset_seg got %b want 1111111", seven); end
        digits_in = 16'h9ABC;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        checks++; if (digit_select !== 4'b1111) begin errors++; $display("FAIL post_reset_blank got %b want 1111", digit_select); end
        step();
        checks++; if (digit_select !== 4'b1110 || seven !== 7'b1000110) begin errors++; $display("FAIL post_reset_slot0 got %b/%b want 1110/1000110", digit_select, seven); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL post_reset_fd got %b want 1", frame_done); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_anti_tearing();
        test_lzs();
        test_enable();
        test_tick_in_blank();
        test_mid_drive_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing scheduler for the shared 7-segment bus of the 4-digit display. Arbitrates the segment bus between the four digit anodes.
- Paced by the 1 kHz scan enable from the clock divider.
- Inserts a blanking gap between digits to prevent ghosting.
- Snapshots display data once per frame to prevent tearing.
- Applies a per-digit enable mask and optional leading-zero suppression.
- Sits between the counter/mode logic and the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (fixed at 4 in this revision).
- BLANK_CYCLES, 16, clk_100mhz cycles that all anodes are off between slots; legal range 1..255.

Ports:
- clk_100mhz  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- scan_tick  input  1  one-cycle enable pulse (1 kHz) that ends the current slot.
- digits_in  input  16  four hex nibbles; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
- digit_en  input  4  per-digit enable mask; bit i enables digit i.
- lzs_en  input  1  leading-zero suppression enable.
- digit_select  output  4  active-low anodes; bit i = digit i.
- digit_select_off  output  4  anodes of unused board digits; constant 4'b1111.
- seven  output  7  active-low segments {g,f,e,d,c,b,a}.
- frame_done  output  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset (async, reset_n=0):
  - state=S_BLANK, slot=0, blank counter=BLANK_CYCLES-1, shadow=16'h0000.
  - digit_select=4'b1111, seven=7'b1111111, frame_done=0.
  - Outputs go to these values immediately, without waiting for a clock edge.
- All outputs are registered. They update on the same edge as the state transition that causes them.
- S_DRIVE:
  - digit_select drives the bit for the current slot low; seven shows the decoded shadow nibble for that slot.
  - Stays in S_DRIVE until scan_tick=1 is sampled.
  - On that edge: state goes to S_BLANK, slot advances (3 wraps to 0), counter loads BLANK_CYCLES-1, digit_select=4'b1111, seven=7'b1111111.
- S_BLANK:
  - Counter decrements each cycle; scan_tick is ignored.
  - On the edge where the counter equals 0: state goes to S_DRIVE and outputs show the new slot.
  - Anodes are therefore off for exactly BLANK_CYCLES cycles.
- Frame snapshot:
  - On the S_BLANK to S_DRIVE edge with slot==0: shadow <= digits_in, and frame_done goes to 1 for exactly that first S_DRIVE cycle.
  - Slot 0's output on that edge is decoded from digits_in directly, so the new value is visible the same cycle.
  - Changes to digits_in at any other time have no effect until the next frame.
- digit_en:
  - If digit_en[slot]=0, the anode stays high and seven=7'b1111111 for the whole slot.
  - Slot timing is unchanged, so brightness stays uniform.
  - digit_en is sampled live, not snapshotted.
- Leading-zero suppression (lzs_en=1):
  - Digit i (i>=1) is blanked (anode off, segments off) if its shadow nibble is 0 and every more-significant nibble is 0.
  - Digit 0 is never suppressed.
  - lzs_en is sampled live.
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - scan_tick arriving in the same cycle the blank counter expires is ignored; S_DRIVE is entered.
  - A scan_tick held high for several cycles ends only the current slot, because blank absorbs the remaining cycles.
- Reset mid-operation: reset aborts the current slot. After release, the first digit (slot 0, from a fresh snapshot) appears BLANK_CYCLES cycles later.

Decomposition:
- Package seg7_pkg:
  - state enum {S_BLANK, S_DRIVE}.
  - SEG_BLANK=7'b1111111 and ANODE_OFF=4'b1111.
  - The 16 hex segment constants.
- Sub-module hex_to_seg7: combinational 4-bit nibble to 7-bit active-low pattern. Instantiated once and fed through a slot-indexed mux.

Test Plan:
- Reset and first slot: BLANK_CYCLES=4, digits_in=16'h1234, reset_n pulse low.
  - During reset: digit_select=1111, seven=1111111, digit_select_off=1111.
  - 4 cycles after release: digit_select=1110, seven=0011001, frame_done=1 for 1 cycle.
- Full scan: scan_tick every 20 cycles.
  - Slot sequence: 1110/0011001, then 1101/0110000, then 1011/0100100, then 0111/1111001, then back to 1110.
  - Each slot is preceded by exactly 4 cycles of 1111/1111111.
- Anti-tearing: change digits_in to 16'h5678 while slot 1 is shown.
  - Slots 2 and 3 still show 2 and 1.
  - Next slot 0 shows 8 (0000000) with a frame_done pulse; slot 3 then shows 5 (0010010).
- Leading-zero suppression: lzs_en=1, digits_in=16'h0070.
  - Slots 3 and 2 give anodes 1111 for their full duration; slot 1 shows 1111000; slot 0 shows 1000000.
  - digits_in=16'h0000: only digit 0 is lit, showing 1000000.
- Enable mask: digit_en=4'b0101 with 16'h1234.
  - Slots 1 and 3 stay 1111/1111111; slots 0 and 2 are normal; scan period is unchanged.
- Tick in blank and mid-drive reset:
  - scan_tick pulses during S_BLANK leave the slot count unchanged.
  - reset_n dropped mid-S_DRIVE forces digit_select=1111 before the next clk_100mhz edge.
